// File: rtl/hwpe_stream_rr_burst_arbiter_if.sv
// hwpe_stream_intf_stream: minimal HWPE stream bundle (valid/ready handshake
// with data and byte strobe) used by hwpe_stream_rr_burst_arbiter.
//   source modport : drives valid/data/strb, receives ready
//   sink modport   : receives valid/data/strb, drives ready
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_rr_burst_arbiter.sv
// hwpe_stream_rr_burst_arbiter
// Round-robin arbiter serializing NB_STREAMS upstream HWPE streams onto one
// downstream stream. A grant is decided in IDLE (one bubble cycle) and then
// held for a burst; the datapath while granted is purely combinational.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous soft clear (same effect as reset)
//   test_mode_i     unused
//   push_i[]        requester streams (sink side)
//   pop_o           shared output stream (source side)
//   grant_o         one-hot current owner, zero when no grant is active
//
// Build option: HWPE_STREAM_ARB_BURST_EN
//   defined   : grants last up to MAX_BURST handshakes
//   undefined : every grant ends after its first handshake, no beat counter
//
// NB_STREAMS must be >= 2 and MAX_BURST >= 1.
module hwpe_stream_rr_burst_arbiter #(
    parameter int unsigned NB_STREAMS = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   test_mode_i,
    hwpe_stream_intf_stream.sink   push_i [NB_STREAMS-1:0],
    hwpe_stream_intf_stream.source pop_o,
    output logic [NB_STREAMS-1:0]  grant_o
);

    localparam int unsigned PTR_W  = $clog2(NB_STREAMS);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] own_q, own_d;

    // Flattened view of the requester interfaces so they can be indexed by
    // the registered owner.
    logic [NB_STREAMS-1:0]                 push_valid;
    logic [NB_STREAMS-1:0]                 push_ready;
    logic [NB_STREAMS-1:0][DATA_WIDTH-1:0] push_data;
    logic [NB_STREAMS-1:0][STRB_W-1:0]     push_strb;

    logic                  pop_valid;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [STRB_W-1:0]     pop_strb;

    logic                  any_valid;
    logic [PTR_W-1:0]      pick;
    logic                  last_beat;
    logic [PTR_W-1:0]      own_next;

    for (genvar k = 0; k < NB_STREAMS; k++) begin : g_flat
        assign push_valid[k] = push_i[k].valid;
        assign push_data[k]  = push_i[k].data;
        assign push_strb[k]  = push_i[k].strb;
        assign push_i[k].ready = push_ready[k];
    end

    assign pop_o.valid = pop_valid;
    assign pop_o.data  = pop_data;
    assign pop_o.strb  = pop_strb;

    // test_mode_i has no function; MAX_BURST is referenced so the
    // burst-disabled build does not leave it dangling.
    logic unused_cfg;
    assign unused_cfg = test_mode_i | (MAX_BURST == 0);

    assign any_valid = |push_valid;

    // First valid requester scanning ptr, ptr+1, ... modulo NB_STREAMS.
    always_comb begin : p_pick
        logic             found;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        pick  = '0;
        for (int unsigned i = 0; i < NB_STREAMS; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % NB_STREAMS);
            if (!found && push_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Priority after a grant: the requester just served goes to the back.
    assign own_next = (own_q == PTR_W'(NB_STREAMS - 1)) ? '0 : own_q + 1'b1;

`ifdef HWPE_STREAM_ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_d      = own_q;
`ifdef HWPE_STREAM_ARB_BURST_EN
        cnt_d      = cnt_q;
`endif
        push_ready = '0;
        pop_valid  = 1'b0;
        pop_data   = '0;
        pop_strb   = '0;
        grant_o    = '0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    own_d   = pick;
`ifdef HWPE_STREAM_ARB_BURST_EN
                    cnt_d   = '0;
`endif
                    state_d = GRANT;
                end
            end
            GRANT: begin
                pop_valid          = push_valid[own_q];
                pop_data           = push_data[own_q];
                pop_strb           = push_strb[own_q];
                push_ready[own_q]  = pop_o.ready;
                grant_o[own_q]     = 1'b1;
                if (!push_valid[own_q]) begin
                    // Owner has nothing pending: release without losing a beat.
                    state_d = IDLE;
                    ptr_d   = own_next;
                end else if (pop_o.ready) begin
`ifdef HWPE_STREAM_ARB_BURST_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                    if (last_beat) begin
                        state_d = IDLE;
                        ptr_d   = own_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_rr_burst_arbiter.sv
// Self-checking bench for hwpe_stream_rr_burst_arbiter with 3 requesters.
// Works for both builds: burst length is MAX_BURST with
// HWPE_STREAM_ARB_BURST_EN defined, 1 otherwise.
module tb_hwpe_stream_rr_burst_arbiter;

    localparam int NB = 3;
    localparam int DW = 16;
    localparam int SW = DW / 8;
    localparam int MB = 4;
`ifdef HWPE_STREAM_ARB_BURST_EN
    localparam int B = MB;
`else
    localparam int B = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic test_mode = 1'b0;
    logic pop_ready = 1'b1;
    logic [NB-1:0] en = '0;
    int limit [NB] = '{default: -1};
    int hs_cnt [NB] = '{default: 0};
    int exp_cnt [NB] = '{default: 0};

    logic [NB-1:0]         src_valid, src_ready;
    logic [NB-1:0][DW-1:0] src_data;
    logic [NB-1:0][SW-1:0] src_strb;
    logic                  pop_valid;
    logic [DW-1:0]         pop_data;
    logic [SW-1:0]         pop_strb;
    logic [NB-1:0]         grant;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [NB-1:0] en;
        bit            rdy;
        bit            clr;
        int            owner;  // -1: no grant expected
        bit            vld;
    } cyc_t;
    cyc_t sbq[$];

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if [NB-1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

    hwpe_stream_rr_burst_arbiter #(
        .NB_STREAMS(NB), .DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .test_mode_i(test_mode),
        .push_i(push_if), .pop_o(pop_if), .grant_o(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_data(input int k, input int c);
        return DW'(k * 4096 + (c % 4096));
    endfunction

    function automatic logic [SW-1:0] exp_strb(input int k);
        return SW'(k + 1);
    endfunction

    function automatic logic [NB-1:0] onehot(input int o, input bit on);
        logic [NB-1:0] v;
        v = '0;
        if (o >= 0 && on) v[o] = 1'b1;
        return v;
    endfunction

    // Requester k: stream-compliant source whose payload encodes its id and
    // the number of beats it has already delivered.
    for (genvar k = 0; k < NB; k++) begin : g_src
        assign src_valid[k] = en[k] && (limit[k] < 0 || hs_cnt[k] < limit[k]);
        assign src_data[k]  = exp_data(k, hs_cnt[k]);
        assign src_strb[k]  = exp_strb(k);
        assign push_if[k].valid = src_valid[k];
        assign push_if[k].data  = src_data[k];
        assign push_if[k].strb  = src_strb[k];
        assign src_ready[k] = push_if[k].ready;
    end

    assign pop_if.ready = pop_ready;
    assign pop_valid = pop_if.valid;
    assign pop_data  = pop_if.data;
    assign pop_strb  = pop_if.strb;

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++)
            if (src_valid[k] && src_ready[k]) hs_cnt[k] <= hs_cnt[k] + 1;
    end

    task automatic add(input logic [NB-1:0] e, input bit r, input bit c,
                       input int o, input bit v);
        cyc_t x;
        x.en = e; x.rdy = r; x.clr = c; x.owner = o; x.vld = v;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        en = '1; pop_ready = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({pop_valid, pop_data, pop_strb, grant, src_ready} !== '0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: vld=%b data=%h strb=%b grant=%b rdy=%b, want all zero",
                         i, pop_valid, pop_data, pop_strb, grant, src_ready);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (pop_valid !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL reset_release: vld=%b grant=%b, want 0/000", pop_valid, grant);
        end
    endtask

    task automatic test_round_robin();
        int c;
        c = 0;
        for (int g = 0; g < 6; g++) begin
            for (int b = 0; b < B; b++) add('1, 1'b1, 1'b0, g % NB, 1'b1);
            add((g == 5) ? '0 : '1, 1'b1, 1'b0, -1, 1'b0);
        end
        while (sbq.size() != 0) begin
            cyc_t t;
            t = sbq.pop_front();
            @(posedge clk); #1 en = t.en; pop_ready = t.rdy; clear = t.clr;
            @(negedge clk);
            n_chk++;
            if (pop_valid !== t.vld || grant !== onehot(t.owner, 1'b1) ||
                src_ready !== onehot(t.owner, t.rdy)) begin
                n_fail++;
                $display("FAIL round_robin cyc %0d: vld/grant/rdy=%b/%b/%b, want %b/%b/%b", c,
                         pop_valid, grant, src_ready, t.vld, onehot(t.owner, 1'b1), onehot(t.owner, t.rdy));
            end
            if (t.vld) begin
                n_chk++;
                if (pop_data !== exp_data(t.owner, exp_cnt[t.owner]) || pop_strb !== exp_strb(t.owner)) begin
                    n_fail++;
                    $display("FAIL round_robin_data cyc %0d: got %h/%b, want %h/%b", c, pop_data, pop_strb,
                             exp_data(t.owner, exp_cnt[t.owner]), exp_strb(t.owner));
                end
                if (t.rdy) exp_cnt[t.owner]++;
            end
            c++;
        end
    endtask

    task automatic test_early_release();
        int c;
        c = 0;
        limit[0] = hs_cnt[0] + 2;
        limit[1] = hs_cnt[1] + B;
`ifdef HWPE_STREAM_ARB_BURST_EN
        add(3'b011, 1'b1, 1'b0, -1, 1'b0);
        add(3'b011, 1'b1, 1'b0, 0, 1'b1);
        add(3'b011, 1'b1, 1'b0, 0, 1'b1);
        add(3'b011, 1'b1, 1'b0, 0, 1'b0);   // owner dry: grant released
        add(3'b011, 1'b1, 1'b0, -1, 1'b0);
        for (int b = 0; b < B; b++) add(3'b011, 1'b1, 1'b0, 1, 1'b1);
        add(3'b000, 1'b1, 1'b0, -1, 1'b0);
`else
        add(3'b011, 1'b1, 1'b0, -1, 1'b0);
        add(3'b011, 1'b1, 1'b0, 0, 1'b1);
        add(3'b011, 1'b1, 1'b0, -1, 1'b0);
        add(3'b011, 1'b1, 1'b0, 1, 1'b1);
        add(3'b011, 1'b1, 1'b0, -1, 1'b0);
        add(3'b011, 1'b1, 1'b0, 0, 1'b1);
        add(3'b000, 1'b1, 1'b0, -1, 1'b0);
`endif
        while (sbq.size() != 0) begin
            cyc_t t;
            t = sbq.pop_front();
            @(posedge clk); #1 en = t.en; pop_ready = t.rdy; clear = t.clr;
            @(negedge clk);
            n_chk++;
            if (pop_valid !== t.vld || grant !== onehot(t.owner, 1'b1) ||
                src_ready !== onehot(t.owner, t.rdy)) begin
                n_fail++;
                $display("FAIL early_release cyc %0d: vld/grant/rdy=%b/%b/%b, want %b/%b/%b", c,
                         pop_valid, grant, src_ready, t.vld, onehot(t.owner, 1'b1), onehot(t.owner, t.rdy));
            end
            if (t.vld) begin
                n_chk++;
                if (pop_data !== exp_data(t.owner, exp_cnt[t.owner]) || pop_strb !== exp_strb(t.owner)) begin
                    n_fail++;
                    $display("FAIL early_release_data cyc %0d: got %h/%b, want %h/%b", c, pop_data, pop_strb,
                             exp_data(t.owner, exp_cnt[t.owner]), exp_strb(t.owner));
                end
                if (t.rdy) exp_cnt[t.owner]++;
            end
            c++;
        end
        limit[0] = -1;
        limit[1] = -1;
    endtask

    task automatic test_mid_clear();
        int c, p;
        c = 0;
        p = (B >= 3) ? 2 : 0;
        add(3'b010, 1'b1, 1'b0, -1, 1'b0);
        for (int b = 0; b < p; b++) add(3'b010, 1'b1, 1'b0, 1, 1'b1);
        add(3'b111, 1'b0, 1'b1, 1, 1'b1);   // clear while owner still valid
        add(3'b111, 1'b1, 1'b0, -1, 1'b0);  // aborted: back in IDLE, ptr = 0
        for (int b = 0; b < B; b++) add(3'b111, 1'b1, 1'b0, 0, 1'b1);
        add(3'b000, 1'b1, 1'b0, -1, 1'b0);
        while (sbq.size() != 0) begin
            cyc_t t;
            t = sbq.pop_front();
            @(posedge clk); #1 en = t.en; pop_ready = t.rdy; clear = t.clr;
            @(negedge clk);
            n_chk++;
            if (pop_valid !== t.vld || grant !== onehot(t.owner, 1'b1) ||
                src_ready !== onehot(t.owner, t.rdy)) begin
                n_fail++;
                $display("FAIL mid_clear cyc %0d: vld/grant/rdy=%b/%b/%b, want %b/%b/%b", c,
                         pop_valid, grant, src_ready, t.vld, onehot(t.owner, 1'b1), onehot(t.owner, t.rdy));
            end
            if (t.vld) begin
                n_chk++;
                if (pop_data !== exp_data(t.owner, exp_cnt[t.owner]) || pop_strb !== exp_strb(t.owner)) begin
                    n_fail++;
                    $display("FAIL mid_clear_data cyc %0d: got %h/%b, want %h/%b", c, pop_data, pop_strb,
                             exp_data(t.owner, exp_cnt[t.owner]), exp_strb(t.owner));
                end
                if (t.rdy) exp_cnt[t.owner]++;
            end
            c++;
        end
        clear = 1'b0;
    endtask

    task automatic test_backpressure();
        int c;
        c = 0;
        add(3'b100, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 10; i++) add(3'b100, 1'b0, 1'b0, 2, 1'b1);
        for (int b = 0; b < B; b++) add(3'b100, 1'b1, 1'b0, 2, 1'b1);
        add(3'b000, 1'b1, 1'b0, -1, 1'b0);
        while (sbq.size() != 0) begin
            cyc_t t;
            t = sbq.pop_front();
            @(posedge clk); #1 en = t.en; pop_ready = t.rdy; clear = t.clr;
            @(negedge clk);
            n_chk++;
            if (pop_valid !== t.vld || grant !== onehot(t.owner, 1'b1) ||
                src_ready !== onehot(t.owner, t.rdy)) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d: vld/grant/rdy=%b/%b/%b, want %b/%b/%b", c,
                         pop_valid, grant, src_ready, t.vld, onehot(t.owner, 1'b1), onehot(t.owner, t.rdy));
            end
            if (t.vld) begin
                n_chk++;
                if (pop_data !== exp_data(t.owner, exp_cnt[t.owner]) || pop_strb !== exp_strb(t.owner)) begin
                    n_fail++;
                    $display("FAIL backpressure_data cyc %0d: got %h/%b, want %h/%b", c, pop_data, pop_strb,
                             exp_data(t.owner, exp_cnt[t.owner]), exp_strb(t.owner));
                end
                if (t.rdy) exp_cnt[t.owner]++;
            end
            c++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_early_release();
        test_mid_clear();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
